// File: rtl/neureka_tcdm_split_reorder_pkg.sv
// Shared types and constants for the wide-to-32-bit TCDM split with response reorder.
// Optional feature macro: NEUREKA_SPLIT_PERF_CNT_EN (request stall counter).
package neureka_tcdm_split_reorder_pkg;

    localparam int unsigned NEUREKA_MEM_BANDWIDTH_EXT = 288;
    localparam int unsigned NEUREKA_SPLIT_FIFO_DEPTH  = 2;

    typedef struct packed {
        logic        req;
        logic [31:0] add;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] data;
    } tcdm_chan_req_t;

    typedef struct packed {
        logic [31:0] r_data;
        logic        r_valid;
    } tcdm_chan_rsp_t;

    // Byte address of channel idx for a wide access starting at base (32-bit wrap).
    function automatic logic [31:0] chan_addr(input logic [31:0] base, input int unsigned idx);
        return base + 32'(idx * 4);
    endfunction

endpackage

// File: rtl/neureka_tcdm_split_reorder_if.sv
// Wide HCI-style request/response bundle between the accelerator master and the split.
interface neureka_tcdm_split_reorder_if #(
    parameter int unsigned BW = 288
) ();
    logic            req;
    logic            gnt;
    logic [31:0]     add;
    logic            wen;
    logic [BW/8-1:0] be;
    logic [BW-1:0]   data;
    logic [BW-1:0]   r_data;
    logic            r_valid;
    logic            r_ready;

    modport master (output req, add, wen, be, data, r_ready,
                    input  gnt, r_data, r_valid);
    modport slave  (input  req, add, wen, be, data, r_ready,
                    output gnt, r_data, r_valid);
endinterface

// File: rtl/neureka_tcdm_split_reorder_fifo.sv
// Per-channel registered response FIFO with a read credit counter.
// The credit counts reads granted on the channel that are not yet popped,
// so a read is only issued when buffer space is guaranteed for its response.
module neureka_split_resp_fifo
    import neureka_tcdm_split_reorder_pkg::*;
#(
    parameter int unsigned DEPTH = NEUREKA_SPLIT_FIFO_DEPTH
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           clear_i,
    input  logic           rd_grant_i,
    input  tcdm_chan_rsp_t rsp_i,
    input  logic           pop_i,
    output logic [31:0]    head_o,
    output logic           valid_o,
    output logic           credit_ok_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d, credit_q, credit_d;
    logic          push;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Responses without an outstanding read (e.g. write acks) are dropped.
    assign push        = rsp_i.r_valid && (credit_q > count_q);
    assign valid_o     = (count_q != '0);
    assign head_o      = mem_q[rptr_q];
    // A pop in the same cycle frees a slot, which keeps one read per cycle flowing.
    assign credit_ok_o = (credit_q < CW'(DEPTH)) || pop_i;

    // Next-state of pointers, occupancy and credits.
    always_comb begin
        rptr_d   = pop_i ? ptr_next(rptr_q) : rptr_q;
        wptr_d   = push  ? ptr_next(wptr_q) : wptr_q;
        count_d  = count_q;
        credit_d = credit_q;
        case ({push, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        case ({rd_grant_i, pop_i})
            2'b10:   credit_d = credit_q + 1'b1;
            2'b01:   credit_d = credit_q - 1'b1;
            default: credit_d = credit_q;
        endcase
    end

    // Control state: reset and soft clear return the FIFO to empty with no credits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q   <= '0;
            wptr_q   <= '0;
            count_q  <= '0;
            credit_q <= '0;
        end else if (clear_i) begin
            rptr_q   <= '0;
            wptr_q   <= '0;
            count_q  <= '0;
            credit_q <= '0;
        end else begin
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            credit_q <= credit_d;
        end
    end

    // Data storage, written on push only.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= rsp_i.r_data;
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && !pop_i && (count_q == CW'(DEPTH))))
        else $error("response push into full channel FIFO");
    a_clear_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
        clear_i |-> (credit_q == count_q))
        else $error("clear_i asserted with reads in flight");
`endif

endmodule

// File: rtl/neureka_tcdm_split_reorder.sv
// Splits one wide request into MP independently granted 32-bit TCDM channels and
// reassembles the in-order per-channel read responses into one wide response.
// Optional feature macro: NEUREKA_SPLIT_PERF_CNT_EN (request stall counter on perf_stall_o).
module neureka_tcdm_split_reorder
    import neureka_tcdm_split_reorder_pkg::*;
#(
    parameter int unsigned BW           = NEUREKA_MEM_BANDWIDTH_EXT,
    parameter int unsigned FIFO_DEPTH   = NEUREKA_SPLIT_FIFO_DEPTH,
    parameter bit          SKIP_ZERO_BE = 1'b1,
    localparam int unsigned MP          = BW / 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    neureka_tcdm_split_reorder_if.slave wide,
    output logic [MP-1:0]          tcdm_req_o,
    input  logic [MP-1:0]          tcdm_gnt_i,
    output logic [MP-1:0][31:0]    tcdm_add_o,
    output logic [MP-1:0]          tcdm_wen_o,
    output logic [MP-1:0][3:0]     tcdm_be_o,
    output logic [MP-1:0][31:0]    tcdm_data_o,
    input  logic [MP-1:0][31:0]    tcdm_r_data_i,
    input  logic [MP-1:0]          tcdm_r_valid_i,
    output logic [31:0]            perf_stall_o
);
    logic [MP-1:0]       done_q, done_d;
    logic [MP-1:0]       skip, credit_ok, chan_hs, chan_ok, not_empty;
    logic [MP-1:0][31:0] heads;
    logic                gnt, rsp_valid, pop;
    tcdm_chan_req_t      chan_req [MP];
    tcdm_chan_rsp_t      chan_rsp [MP];

    for (genvar i = 0; i < MP; i++) begin : g_chan
        assign skip[i] = SKIP_ZERO_BE && !wide.wen && (wide.be[4*i +: 4] == 4'b0000);

        assign chan_req[i].req  = wide.req && !done_q[i] && !skip[i] && (wide.wen ? credit_ok[i] : 1'b1);
        assign chan_req[i].add  = chan_addr(wide.add, i);
        assign chan_req[i].wen  = wide.wen;
        assign chan_req[i].be   = wide.be[4*i +: 4];
        assign chan_req[i].data = wide.data[32*i +: 32];

        assign tcdm_req_o[i]  = chan_req[i].req;
        assign tcdm_add_o[i]  = chan_req[i].add;
        assign tcdm_wen_o[i]  = chan_req[i].wen;
        assign tcdm_be_o[i]   = chan_req[i].be;
        assign tcdm_data_o[i] = chan_req[i].data;

        assign chan_hs[i] = chan_req[i].req && tcdm_gnt_i[i];
        assign chan_ok[i] = done_q[i] || skip[i] || chan_hs[i];

        assign chan_rsp[i].r_data  = tcdm_r_data_i[i];
        assign chan_rsp[i].r_valid = tcdm_r_valid_i[i];

        neureka_split_resp_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) i_fifo (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .clear_i     (clear_i),
            .rd_grant_i  (chan_hs[i] && wide.wen),
            .rsp_i       (chan_rsp[i]),
            .pop_i       (pop),
            .head_o      (heads[i]),
            .valid_o     (not_empty[i]),
            .credit_ok_o (credit_ok[i])
        );
    end

    assign gnt          = wide.req && (&chan_ok);
    assign wide.gnt     = gnt;
    assign rsp_valid    = &not_empty;
    assign pop          = rsp_valid && wide.r_ready;
    assign wide.r_valid = rsp_valid;
    assign wide.r_data  = rsp_valid ? heads : '0;

    // Done bits collect channel handshakes until the whole wide request is granted.
    always_comb begin
        done_d = gnt ? '0 : (done_q | chan_hs);
    end

    // Per-channel completion tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      done_q <= '0;
        else if (clear_i) done_q <= '0;
        else              done_q <= done_d;
    end

`ifdef NEUREKA_SPLIT_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (wide.req && !gnt && (perf_q != '1)) perf_d = perf_q + 32'd1;
    end

    // Saturating count of cycles the master waits for the wide grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      perf_q <= '0;
        else if (clear_i) perf_q <= '0;
        else              perf_q <= perf_d;
    end

    assign perf_stall_o = perf_q;
`else
    assign perf_stall_o = '0;
`endif

`ifndef SYNTHESIS
    logic pend_q;

    // Remembers that a wide request was left pending at the last edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      pend_q <= 1'b0;
        else if (clear_i) pend_q <= 1'b0;
        else              pend_q <= wide.req && !gnt;
    end

    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
        pend_q |-> (wide.req && $stable(wide.add) && $stable(wide.wen)
                    && $stable(wide.be) && $stable(wide.data)))
        else $error("wide request changed before grant");
`endif

endmodule

// File: doc/neureka_tcdm_split_reorder.md
Name: neureka_tcdm_split_reorder

Overview:
- Parametrised successor to the fixed wide-to-32-bit TCDM split used in the accelerator wrap.
- Splits one BW-bit HCI-style request into MP independent 32-bit TCDM channels. Each channel is granted independently (no lockstep grant).
- Per-channel read responses are buffered in FIFOs and reassembled into a single BW-bit response with ready backpressure.
- Optionally skips write channels whose byte-enable slice is all zero. Sits between neureka_top's tcdm master and the cluster TCDM ports.

Parameters:
- BW, NEUREKA_MEM_BANDWIDTH_EXT, wide data width; multiple of 32.
- MP, BW/32, number of 32-bit channels.
- FIFO_DEPTH, 2, response FIFO depth per channel; must be at least 1.
- SKIP_ZERO_BE, 1, 1 = write channels with be slice == 0 are not issued.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous soft clear
- req_i  in  1  wide request
- gnt_o  out  1  wide grant
- add_i  in  32  wide byte address, 4-byte aligned
- wen_i  in  1  1 = read, 0 = write
- be_i  in  BW/8  byte enables
- data_i  in  BW  write data
- r_data_o  out  BW  reassembled read data
- r_valid_o  out  1  read response valid
- r_ready_i  in  1  read response ready
- tcdm_req_o  out  MP  channel requests
- tcdm_gnt_i  in  MP  channel grants
- tcdm_add_o  out  MPx32  channel addresses
- tcdm_wen_o  out  MP  channel wen
- tcdm_be_o  out  MPx4  channel byte enables
- tcdm_data_o  out  MPx32  channel write data
- tcdm_r_data_i  in  MPx32  channel read data
- tcdm_r_valid_i  in  MP  channel read valid
- perf_stall_o  out  32  request stall counter (see Optional Feature)

Behaviour:
- Reset / clear state: done bits = 0, credits = 0, FIFOs empty, gnt_o = 0, r_valid_o = 0, r_data_o = 0, perf_stall_o = 0.
- Channel i address: tcdm_add_o[i] = add_i + 4*i, 32-bit wrap.
- Channel i byte enables and data: be_i[4i+3:4i] and data_i[32i+31:32i]. tcdm_wen_o[i] = wen_i.
- skip[i] = SKIP_ZERO_BE & ~wen_i & (be slice == 0). Reads never skip.
- tcdm_req_o[i] = req_i & ~done[i] & ~skip[i] & (wen_i ? credit[i] < FIFO_DEPTH : 1).
- Channel handshake: tcdm_req_o[i] & tcdm_gnt_i[i] sets done[i] at the clock edge.
- Wide grant: gnt_o = req_i & AND over i of (done[i] | skip[i] | (tcdm_req_o[i] & tcdm_gnt_i[i])). It is combinational, so the grant can occur in the same cycle as the last channel grant.
- On gnt_o, all done bits clear.
- Master holds req_i, add_i, wen_i, be_i and data_i stable from req_i high until gnt_o. A change during that window is a protocol error and is flagged by a simulation assertion.
- Credits: credit[i] += 1 on a read channel grant; credit[i] -= 1 on a wide pop. Simultaneous increment and decrement leaves the value unchanged. Width is $clog2(FIFO_DEPTH+1).
- FIFO push: on tcdm_r_valid_i[i] only. Writes produce no response, and channel r_valid for writes is ignored. A push into a full FIFO cannot occur because of credits; a simulation assertion checks this.
- Response: r_valid_o = all MP FIFOs non-empty. r_data_o = concatenation of the FIFO heads, channel 0 in the LSBs.
- Pop all heads when r_valid_o & r_ready_i.
- FIFOs are registered, not fall-through: r_valid_o rises at the earliest 1 cycle after the last channel r_valid.
- Per-channel ordering is in-order, so reassembly needs no tags.
- Throughput: with FIFO_DEPTH >= 2, all channels granting every cycle and r_ready_i = 1, one wide read per cycle is sustained.
- clear_i: same effect as reset, in one cycle. It is legal only when all credits equal the number of buffered entries (no reads in flight); a simulation assertion flags violations.
- An all-zero-be write with SKIP_ZERO_BE = 1 is granted in the same cycle with no channel request.

Optional Feature:
- Macro: NEUREKA_SPLIT_PERF_CNT_EN.
- Defined: perf_stall_o counts cycles with req_i & ~gnt_o. It saturates at 2^32-1 and is zeroed by reset and by clear_i.
- Undefined: perf_stall_o is tied to 0 and no counter logic is generated. The port exists in both cases.

Decomposition:
- In neureka_package:
  - NEUREKA_SPLIT_FIFO_DEPTH = 2.
  - Typedef tcdm_chan_req_t {req, add[31:0], wen, be[3:0], data[31:0]}.
  - Typedef tcdm_chan_rsp_t {r_data[31:0], r_valid}.
- One sub-module, neureka_split_resp_fifo: per-channel FIFO with credit counter, instantiated MP times in a generate loop.

Test Plan:
- MP = 4, read at 0x1000, all gnt high; r_valid on all channels the next cycle with data 0xA0..0xA3 -> gnt_o in the same cycle; addresses 0x1000/4/8/C; r_valid_o 1 cycle later with r_data_o = {A3,A2,A1,A0}.
- Staggered grants: ch0 at cycle 0, ch2 at cycle 1, ch1 and ch3 at cycle 3 -> each channel issues exactly once; gnt_o only at cycle 3; no re-request after a channel's own grant.
- Write, be = 0x00F0 (MP = 4), SKIP_ZERO_BE = 1 -> only tcdm_req_o[1] asserted; gnt_o when ch1 is granted. The same stimulus with SKIP_ZERO_BE = 0 -> all 4 channels requested.
- FIFO_DEPTH = 2, r_ready_i = 0, back-to-back reads -> two reads granted; third read gets tcdm_req_o = 0 until a pop with r_ready_i = 1; no data lost or reordered.
- clear_i with idle datapath after 5 stalled cycles -> all state zeroed next cycle. With NEUREKA_SPLIT_PERF_CNT_EN defined, perf_stall_o reads 5 before the clear and 0 after it.
- rst_ni asserted mid-transaction (done = 0101) -> all outputs 0 immediately; the next request reissues all channels.
